seven_seg_scan: RTL
===================

// Module: seven_seg_scan
// PURPOSE
//  Parametrised time-multiplexed N-digit 7-segment scan driver, successor to the fixed 4-digit driver.
//  Per-digit hex/decimal-point/blank data, double-buffered via valid/ready load (tear-free at frame edge).
//  Adds leading-zero suppression, PWM brightness, anti-ghost dead cycle, selectable output polarity.
//  Sits between counter/datapath logic and the board's segment/common pins.
// PARAMETERS
//  N_DIGITS        4   number of digits scanned (2..8)
//  DIV_W           10  slot prescaler width; each digit slot lasts 2**DIV_W clk cycles
//  BRIGHT_W        3   brightness code width (1..DIV_W)
//  SEG_ACTIVE_LOW  1   1: segment lit = 0; 0: lit = 1
//  COM_ACTIVE_LOW  1   1: digit enabled = 0; 0: enabled = 1
// PORTS
//  clk         in   1           clock
//  rst_n       in   1           reset, asynchronous, active-low
//  load_valid  in   1           new frame data offered
//  load_ready  out  1           pending buffer empty; transfer when valid&&ready
//  load_digits in   4*N_DIGITS  nibble i = hex value of digit i (digit 0 = rightmost)
//  load_dp     in   N_DIGITS    decimal point lit per digit
//  load_blank  in   N_DIGITS    force digit i dark
//  lzs_en      in   1           leading-zero suppression enable (live, not buffered)
//  disp_en     in   1           0: all commons inactive (live)
//  bright      in   BRIGHT_W    on-time code, 0 = min, all-ones = full
//  seg         out  8           [7]=dp, [6:0]=g..a, polarity per SEG_ACTIVE_LOW
//  com         out  N_DIGITS    com[i] enables digit i, polarity per COM_ACTIVE_LOW
//  frame_done  out  1           1-cycle pulse at frame boundary
// BEHAVIOUR
//  - Reset: div_cnt=0, idx=0, shadow digits/dp/blank=0, pending empty, load_ready=1,
//    seg=all unlit, com=all inactive, frame_done=0. Reset mid-frame discards pending and shadow.
//  - div_cnt (DIV_W bits) increments every clk, wraps; slot_end when div_cnt==all-ones.
//  - On slot_end: idx = (idx==N_DIGITS-1) ? 0 : idx+1. Frame boundary = slot_end && idx==N_DIGITS-1.
//  - load_ready = !pending_full (registered flag). valid&&ready captures into pending, sets pending_full.
//  - Frame boundary with pending_full: shadow<=pending, pending_full<=0, same edge as idx wrap.
//  - Simultaneous capture and frame boundary: boundary sees old pending_full=0, so no transfer;
//    captured data goes to shadow at the NEXT boundary. No data lost, never torn mid-frame.
//  - frame_done registered: high the cycle after each frame boundary edge.
//  - LZS (lzs_en=1): digit i>0 dark if shadow value 0 and all digits above i are 0; digit 0 never
//    suppressed. dp of a suppressed digit still honoured.
//  - Digit dark (blank or LZS): segments a..g unlit; dp per load_dp.
//  - Slot on-window: on = disp_en && div_cnt!=0 && (div_cnt[DIV_W-1 -: BRIGHT_W] <= bright).
//    div_cnt==0 is dead cycle (all commons inactive) to suppress ghosting.
//  - Outputs registered: seg/com at edge t+1 reflect idx/div_cnt/shadow/inputs sampled at edge t.
//  - com: only bit idx may be active, and only while on; all others inactive. seg = glyph(idx) regardless.
//  - Glyphs (active-high g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//    A=77 b=7C C=39 d=5E E=79 F=71; inverted when SEG_ACTIVE_LOW=1.
// STRUCTURE
//  - seg7_pkg: glyph table constant (16x7), SEG_DP bit index, blank pattern constant.
//  - Sub-module seg7_hex_decode: combinational nibble+dp+dark -> 8-bit active-high pattern.
//  - Top: prescaler, idx counter, pending/shadow regs + handshake, LZS mask, PWM compare, polarity, output regs.
// TESTING
//  1 Reset: rst_n low mid-scan -> next cycle seg=8'hFF, com=4'hF, load_ready=1, frame_done=0 (defaults).
//  2 Scan: DIV_W=2, load 16'h1234 -> after next boundary com cycles 1110,1101,1011,0111 per 4-clk slot,
//    seg=~{0,glyph} for 4,3,2,1 respectively; div_cnt==0 cycle shows com=4'hF; frame_done every 16 clk.
//  3 Double buffer: load A, then load B in same frame -> ready low after A; display switches A->B only
//    at boundary edges; valid on the boundary cycle itself -> shown one frame later.
//  4 LZS: load 16'h0070, lzs_en=1 -> digits 3,2 dark, 1='7', 0='0'; load 16'h0000 -> only digit 0 '0'.
//  5 Brightness: BRIGHT_W=2, DIV_W=4, bright=0 -> com active 3 of 16 cycles per slot; bright=3 -> 15 of 16.
//  6 Blank/dp/disp_en: load_blank=4'b0100, load_dp=4'b0001 -> digit 2 seg=8'hFF, digit 0 seg[7]=0;
//    disp_en=0 -> com=4'hF while scan and frame_done continue.

Source files
------------

// File: rtl/seg7_pkg.sv
//==============================================================================
// seg7_pkg: shared glyph table and segment-bit constants for the scan driver.
// Revision: 1.0
//==============================================================================
`default_nettype none

package seg7_pkg;

    localparam int         SEG_DP    = 7;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Active-high g..a patterns, entry 0 in the least significant 7 bits.
    localparam logic [16*7-1:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        return GLYPH_TABLE[{nib, 3'b000} - {3'b000, nib} +: 7];
    endfunction

endpackage

`default_nettype wire

// File: rtl/seven_seg_scan_if.sv
//==============================================================================
// seven_seg_scan_if: valid/ready frame-load bus carrying per-digit hex/dp/blank.
// Revision: 1.0
//==============================================================================
`default_nettype none

interface seven_seg_scan_if #(
    parameter int N_DIGITS = 4
);
    logic                  load_valid;
    logic                  load_ready;
    logic [4*N_DIGITS-1:0] load_digits;
    logic [N_DIGITS-1:0]   load_dp;
    logic [N_DIGITS-1:0]   load_blank;

    modport master (
        output load_valid, load_digits, load_dp, load_blank,
        input  load_ready
    );

    modport slave (
        input  load_valid, load_digits, load_dp, load_blank,
        output load_ready
    );
endinterface

`default_nettype wire

// File: rtl/seg7_hex_decode.sv
//==============================================================================
// seg7_hex_decode: nibble + dp + dark to active-high {dp, g..a} pattern.
// Revision: 1.0
//==============================================================================
`default_nettype none

module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       dark,
    output logic [7:0] pattern
);

    always_comb begin
        pattern         = SEG_BLANK;
        pattern[SEG_DP] = dp;
        if (!dark) begin
            pattern[6:0] = glyph(nibble);
        end
    end

endmodule

`default_nettype wire

// File: rtl/seven_seg_scan.sv
//==============================================================================
// seven_seg_scan: N-digit multiplexed 7-segment driver, double-buffered load.
// Revision: 1.0
//==============================================================================
`default_nettype none

module seven_seg_scan
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int DIV_W          = 10,
    parameter int BRIGHT_W       = 3,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int COM_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    seven_seg_scan_if.slave     load,
    input  logic                lzs_en,
    input  logic                disp_en,
    input  logic [BRIGHT_W-1:0] bright,
    output logic [7:0]          seg,
    output logic [N_DIGITS-1:0] com,
    output logic                frame_done
);

    localparam int                  IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [7:0]          SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] COM_OFF  = (COM_ACTIVE_LOW != 0) ? '1 : '0;

    logic [DIV_W-1:0]      r_div;
    logic [IDX_W-1:0]      r_idx;
    logic [4*N_DIGITS-1:0] r_pend_digits, r_sh_digits;
    logic [N_DIGITS-1:0]   r_pend_dp,     r_sh_dp;
    logic [N_DIGITS-1:0]   r_pend_blank,  r_sh_blank;
    logic                  r_pend_full;
    logic [7:0]            r_seg;
    logic [N_DIGITS-1:0]   r_com;
    logic                  r_frame_done;

    logic                  w_slot_end;
    logic                  w_frame_bnd;
    logic                  w_capture;
    logic [N_DIGITS-1:0]   w_dark;
    logic [3:0]            w_nib;
    logic                  w_dp;
    logic                  w_dark_cur;
    logic [7:0]            w_pattern;
    logic                  w_on;
    logic [N_DIGITS-1:0]   w_onehot;

    assign w_slot_end      = (r_div == '1);
    assign w_frame_bnd     = w_slot_end && (r_idx == LAST_IDX);
    assign w_capture       = load.load_valid && !r_pend_full;
    assign load.load_ready = !r_pend_full;

    // Prescaler and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
            if (w_slot_end) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    // Capture and transfer are exclusive: capture needs pending empty,
    // transfer needs it full, so a load on the boundary cycle waits a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_digits <= '0;
            r_pend_dp     <= '0;
            r_pend_blank  <= '0;
            r_pend_full   <= 1'b0;
            r_sh_digits   <= '0;
            r_sh_dp       <= '0;
            r_sh_blank    <= '0;
        end else if (w_capture) begin
            r_pend_digits <= load.load_digits;
            r_pend_dp     <= load.load_dp;
            r_pend_blank  <= load.load_blank;
            r_pend_full   <= 1'b1;
        end else if (w_frame_bnd && r_pend_full) begin
            r_sh_digits   <= r_pend_digits;
            r_sh_dp       <= r_pend_dp;
            r_sh_blank    <= r_pend_blank;
            r_pend_full   <= 1'b0;
        end
    end

    // A digit is suppressed while it and every digit above it read zero.
    always_comb begin
        logic run_zero;
        run_zero = 1'b1;
        w_dark   = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            run_zero  = run_zero & (r_sh_digits[4*i +: 4] == 4'h0);
            w_dark[i] = r_sh_blank[i] | (lzs_en & run_zero & (i != 0));
        end
    end

    assign w_nib      = r_sh_digits[{r_idx, 2'b00} +: 4];
    assign w_dp       = r_sh_dp[r_idx];
    assign w_dark_cur = w_dark[r_idx];

    seg7_hex_decode u_decode (
        .nibble  (w_nib),
        .dp      (w_dp),
        .dark    (w_dark_cur),
        .pattern (w_pattern)
    );

    // div_cnt==0 is the anti-ghost dead cycle; the MSBs set the PWM window.
    assign w_on = disp_en && (r_div != '0) && (r_div[DIV_W-1 -: BRIGHT_W] <= bright);

    always_comb begin
        w_onehot        = '0;
        w_onehot[r_idx] = w_on;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg        <= SEG_OFF;
            r_com        <= COM_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= w_pattern ^ SEG_OFF;
            r_com        <= w_onehot ^ COM_OFF;
            r_frame_done <= w_frame_bnd;
        end
    end

    assign seg        = r_seg;
    assign com        = r_com;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire
